full_adder_1_4_wrapper: RTL and testbench
=========================================

# full_adder_1_4_wrapper

Registered 4-bit ripple-carry adder built from four 1-bit full-adder cells, with every operand bit and result bit on its own scalar port. It is the top-level wrapper for the 4-bit adder lab design and is driven directly by testbench or board I/O. It adds two 4-bit operands and a carry-in, then presents the 4-bit sum and carry-out from output registers one clock after sampling.

## Interface

- No parameters; width is fixed at 4 bits.
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk_0  input  1  system clock; all state updates on the rising edge.
- rst_0  input  1  asynchronous active-high reset; clears all output registers.
- in1_0 .. in1_3  input  1 each  operand A, bit 0 (LSB) .. bit 3 (MSB).
- in2_0 .. in2_3  input  1 each  operand B, bit 0 (LSB) .. bit 3 (MSB).
- cin_0  input  1  carry-in, added at bit 0.
- sum_0 .. sum_3  output  1 each  registered sum, bit 0 (LSB) .. bit 3 (MSB).
- cout_0  output  1  registered carry-out from bit 3.

## Operation

- Internal datapath is four 1-bit full-adder cells in a ripple chain.
- Cell i inputs are a=in1_i, b=in2_i, c=carry_i, with carry_0 = cin_0.
- Cell i outputs are s_i = a^b^c and carry_{i+1} = (a&b)|(a&c)|(b&c).
- Combinational result is {carry_4, s_3..s_0} = A + B + cin_0, where A = {in1_3..in1_0} and B = {in2_3..in2_0}. This is 5-bit unsigned arithmetic with no truncation of the carry.
- Output register captures {s_3..s_0} into sum_3..sum_0 and carry_4 into cout_0 on every rising clk_0 edge while rst_0 is low.
- There is no enable and no handshake. Every cycle samples new inputs.
- Overflow: sums above 15 wrap modulo 16 on sum_*, and cout_0 = 1. The maximum case is 15 + 15 + 1 = 31, giving sum = 4'hF and cout_0 = 1.
- X/Z on inputs is not handled; inputs must be driven to known levels.

## Timing

- Reset values: sum_0..sum_3 = 0 and cout_0 = 0.
- Reset applies immediately on rst_0 rising, with no clock required, and holds while rst_0 is high.
- Latency is 1 cycle: inputs stable before rising edge N appear on the outputs after edge N, valid through edge N+1.
- Throughput is one addition per cycle.
- Combinational ripple path of 4 full-adder carry stages must meet a single clk_0 period.
- Reset released mid-operation: the first edge with rst_0 low loads the current inputs' result. No stale pre-reset result ever appears.
- Inputs changing between edges have no effect on the outputs until the next edge.
- Reset asserted concurrently with a clock edge: reset wins and the outputs are 0.

## Test plan

- Reset check: assert rst_0 with in1 = 4'hA, in2 = 4'h5, cin = 1, then clock several edges -> sum = 0 and cout = 0 throughout. Deassert rst_0 -> one edge later sum = 4'h0, cout = 1 (10 + 5 + 1 = 16).
- Count sweep: start from {in1, in2, cin} = 0 and increment the 9-bit concatenation by 1 for 8 steps, one step per cycle.
  - Required sums one cycle later: 1, 1, 2, 2, 3, 3, 4, 4.
  - Required cout: 0 throughout.
- Carry-propagation corner: in1 = 4'hF, in2 = 4'h0, cin = 1 -> sum = 4'h0, cout = 1. Same operands with cin = 0 -> sum = 4'hF, cout = 0.
- Maximum: in1 = 4'hF, in2 = 4'hF, cin = 1 -> sum = 4'hF, cout = 1. Then in1 = 4'h8, in2 = 4'h8, cin = 0 -> sum = 4'h0, cout = 1.
- Mid-stream async reset: pulse rst_0 between clock edges while a nonzero result is showing -> outputs drop to 0 before the next edge. The first edge after release shows the result for the inputs present at that time.
- Exhaustive: all 512 combinations of in1, in2 and cin, one per cycle. Compare {cout, sum} against in1 + in2 + cin one cycle later -> zero mismatches.

Source files
------------

// File: rtl/full_adder_1_4_wrapper.sv
// Registered 4-bit ripple-carry adder from four 1-bit full-adder cells.
// Ports: clk_0, rst_0 (async high), in1_0..3, in2_0..3, cin_0 -> sum_0..3, cout_0.
module full_adder_1_4_wrapper (
  input  logic clk_0,
  input  logic rst_0,
  input  logic in1_0,
  input  logic in1_1,
  input  logic in1_2,
  input  logic in1_3,
  input  logic in2_0,
  input  logic in2_1,
  input  logic in2_2,
  input  logic in2_3,
  input  logic cin_0,
  output logic sum_0,
  output logic sum_1,
  output logic sum_2,
  output logic sum_3,
  output logic cout_0
);

  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] s;
  logic [4:0] carry;
  logic [3:0] sum_q;
  logic       cout_q;

  assign a = {in1_3, in1_2, in1_1, in1_0};
  assign b = {in2_3, in2_2, in2_1, in2_0};
  assign carry[0] = cin_0;

  for (genvar i = 0; i < 4; i++) begin : g_cell
    assign s[i] = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i])
                      | (a[i] & carry[i])
                      | (b[i] & carry[i]);
  end

  always_ff @(posedge clk_0 or posedge rst_0) begin
    if (rst_0) begin
      sum_q  <= 4'h0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= s;
      cout_q <= carry[4];
    end
  end

  assign sum_0  = sum_q[0];
  assign sum_1  = sum_q[1];
  assign sum_2  = sum_q[2];
  assign sum_3  = sum_q[3];
  assign cout_0 = cout_q;

endmodule

// File: tb/tb_full_adder_1_4_wrapper.sv
// Scoreboard bench for full_adder_1_4_wrapper.
// Expected {cout,sum} pushed on drive, popped one edge later.
module tb_full_adder_1_4_wrapper;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [3:0] in1 = 4'h0;
  logic [3:0] in2 = 4'h0;
  logic cin = 1'b0;
  logic [3:0] sum;
  logic cout;

  logic [4:0] sb[$];
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  full_adder_1_4_wrapper dut (
    .clk_0 (clk),
    .rst_0 (rst),
    .in1_0 (in1[0]),
    .in1_1 (in1[1]),
    .in1_2 (in1[2]),
    .in1_3 (in1[3]),
    .in2_0 (in2[0]),
    .in2_1 (in2[1]),
    .in2_2 (in2[2]),
    .in2_3 (in2[3]),
    .cin_0 (cin),
    .sum_0 (sum[0]),
    .sum_1 (sum[1]),
    .sum_2 (sum[2]),
    .sum_3 (sum[3]),
    .cout_0(cout)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: sim did not finish, got timeout want done");
    $fatal(1);
  end

  task automatic drive(input logic [3:0] x, input logic [3:0] y,
                       input logic c);
    logic [4:0] e;
    in1 = x;
    in2 = y;
    cin = c;
    e = {1'b0, x} + {1'b0, y} + {4'b0, c};
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in1 = 4'hA;
    in2 = 4'h5;
    cin = 1'b1;
    #1;
    compared++;
    if ({cout, sum} !== 5'h00) begin
      mismatched++;
      $display("FAIL reset_async: got %h want 00", {cout, sum});
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      compared++;
      if ({cout, sum} !== 5'h00) begin
        mismatched++;
        $display("FAIL reset_hold%0d: got %h want 00", i, {cout, sum});
      end
    end
    rst = 1'b0;
    drive(4'hA, 4'h5, 1'b1);
    tick();
    compared++;
    if ({cout, sum} !== sb.pop_front() || {cout, sum} !== 5'h10) begin
      mismatched++;
      $display("FAIL reset_release: got %h want 10", {cout, sum});
    end
  endtask

  task automatic test_count_sweep();
    logic [8:0] v;
    logic [3:0] want_sum[8];
    want_sum = '{4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd3, 4'd4, 4'd4};
    for (int i = 0; i < 8; i++) begin
      v = 9'(i + 1);
      drive(v[8:5], v[4:1], v[0]);
      tick();
      compared++;
      if ({cout, sum} !== sb.pop_front() ||
          {cout, sum} !== {1'b0, want_sum[i]}) begin
        mismatched++;
        $display("FAIL sweep%0d: got %h want %h", i, {cout, sum},
                 {1'b0, want_sum[i]});
      end
    end
  endtask

  task automatic test_corners();
    logic [4:0] fixed[4];
    logic [4:0] e;
    fixed = '{5'h10, 5'h0F, 5'h1F, 5'h10};
    drive(4'hF, 4'h0, 1'b1);
    tick();
    drive(4'hF, 4'h0, 1'b0);
    tick();
    drive(4'hF, 4'hF, 1'b1);
    tick();
    drive(4'h8, 4'h8, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      e = sb.pop_front();
      compared++;
      if (e !== fixed[i]) begin
        mismatched++;
        $display("FAIL corner_model%0d: got %h want %h", i, e, fixed[i]);
      end
    end
  endtask

  task automatic test_corners_live();
    logic [3:0] x[4];
    logic [3:0] y[4];
    logic c[4];
    logic [4:0] want[4];
    x = '{4'hF, 4'hF, 4'hF, 4'h8};
    y = '{4'h0, 4'h0, 4'hF, 4'h8};
    c = '{1'b1, 1'b0, 1'b1, 1'b0};
    want = '{5'h10, 5'h0F, 5'h1F, 5'h10};
    for (int i = 0; i < 4; i++) begin
      drive(x[i], y[i], c[i]);
      tick();
      compared++;
      if ({cout, sum} !== sb.pop_front() || {cout, sum} !== want[i]) begin
        mismatched++;
        $display("FAIL corner%0d: got %h want %h", i, {cout, sum}, want[i]);
      end
    end
  endtask

  task automatic test_midstream_reset();
    drive(4'h7, 4'h6, 1'b1);
    tick();
    compared++;
    if ({cout, sum} !== sb.pop_front()) begin
      mismatched++;
      $display("FAIL mid_pre: got %h want 0e", {cout, sum});
    end
    #1 rst = 1'b1;
    #1;
    compared++;
    if ({cout, sum} !== 5'h00) begin
      mismatched++;
      $display("FAIL mid_async: got %h want 00", {cout, sum});
    end
    #1 rst = 1'b0;
    drive(4'h3, 4'h9, 1'b0);
    #1;
    compared++;
    if ({cout, sum} !== 5'h00) begin
      mismatched++;
      $display("FAIL mid_no_stale: got %h want 00", {cout, sum});
    end
    tick();
    compared++;
    if ({cout, sum} !== sb.pop_front()) begin
      mismatched++;
      $display("FAIL mid_release: got %h want 0c", {cout, sum});
    end
  endtask

  task automatic test_hold_between_edges();
    logic [4:0] e;
    drive(4'h1, 4'h2, 1'b0);
    tick();
    e = sb.pop_front();
    in1 = 4'hF;
    in2 = 4'hF;
    cin = 1'b1;
    #2;
    compared++;
    if ({cout, sum} !== e) begin
      mismatched++;
      $display("FAIL hold: got %h want %h", {cout, sum}, e);
    end
  endtask

  task automatic test_exhaustive();
    logic [8:0] v;
    logic [4:0] e;
    for (int i = 0; i < 512; i++) begin
      v = 9'(i);
      drive(v[8:5], v[4:1], v[0]);
      tick();
      e = sb.pop_front();
      compared++;
      if ({cout, sum} !== e) begin
        mismatched++;
        $display("FAIL exh a=%h b=%h c=%b: got %h want %h",
                 v[8:5], v[4:1], v[0], {cout, sum}, e);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_count_sweep();
    test_corners();
    test_corners_live();
    test_midstream_reset();
    test_hold_between_edges();
    test_exhaustive();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
